// File: rtl/axi_reg_arbiter.sv
// axi_reg_arbiter: round-robin sequencer sharing one single-beat AXI4 register port between requesters
module axi_reg_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int TXN_ID     = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0]                 req_write,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]                 rsp_valid,
  input  logic [N_REQ-1:0]                 rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_resp,
  output logic                             busy,
  output logic                             timeout_flag,
  output logic [ID_WIDTH-1:0]              s_axi_awid,
  output logic [ADDR_WIDTH-1:0]            s_axi_awaddr,
  output logic [7:0]                       s_axi_awlen,
  output logic [2:0]                       s_axi_awsize,
  output logic [1:0]                       s_axi_awburst,
  output logic                             s_axi_awlock,
  output logic [3:0]                       s_axi_awcache,
  output logic [2:0]                       s_axi_awprot,
  output logic                             s_axi_awvalid,
  input  logic                             s_axi_awready,
  output logic [DATA_WIDTH-1:0]            s_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]          s_axi_wstrb,
  output logic                             s_axi_wlast,
  output logic                             s_axi_wvalid,
  input  logic                             s_axi_wready,
  input  logic [1:0]                       s_axi_bresp,
  input  logic                             s_axi_bvalid,
  output logic                             s_axi_bready,
  output logic [ID_WIDTH-1:0]              s_axi_arid,
  output logic [ADDR_WIDTH-1:0]            s_axi_araddr,
  output logic [7:0]                       s_axi_arlen,
  output logic [2:0]                       s_axi_arsize,
  output logic [1:0]                       s_axi_arburst,
  output logic                             s_axi_arlock,
  output logic [3:0]                       s_axi_arcache,
  output logic [2:0]                       s_axi_arprot,
  output logic                             s_axi_arvalid,
  input  logic                             s_axi_arready,
  input  logic [DATA_WIDTH-1:0]            s_axi_rdata,
  input  logic [1:0]                       s_axi_rresp,
  input  logic                             s_axi_rvalid,
  output logic                             s_axi_rready
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));
  typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;
  state_t st, st_nxt;
  logic [IW-1:0] ptr, gnt, g, idx;
  logic any, accept, txn_wr, aw_ok, w_ok, ar_ok, addr_done, resp_hs, tmo;
  logic [ADDR_WIDTH-1:0] txn_addr;
  logic [DATA_WIDTH-1:0] txn_wdata;
  logic [CW-1:0] cnt;
  assign accept    = rstn && st == IDLE && any;
  assign aw_ok     = !s_axi_awvalid || s_axi_awready;
  assign w_ok      = !s_axi_wvalid || s_axi_wready;
  assign ar_ok     = !s_axi_arvalid || s_axi_arready;
  assign addr_done = txn_wr ? aw_ok && w_ok : ar_ok;
  assign resp_hs   = txn_wr ? s_axi_bvalid && s_axi_bready : s_axi_rvalid && s_axi_rready;
  assign tmo       = TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1) && (st == ADDR || (st == RESP && !resp_hs));
  assign s_axi_awid    = ID_WIDTH'(TXN_ID);
  assign s_axi_awaddr  = txn_addr;
  assign s_axi_awlen   = 8'd0;
  assign s_axi_awsize  = SIZE;
  assign s_axi_awburst = 2'b01;
  assign s_axi_awlock  = 1'b0;
  assign s_axi_awcache = 4'd0;
  assign s_axi_awprot  = 3'd0;
  assign s_axi_wdata   = txn_wdata;
  assign s_axi_wstrb   = '1;
  assign s_axi_wlast   = 1'b1;
  assign s_axi_arid    = ID_WIDTH'(TXN_ID);
  assign s_axi_araddr  = txn_addr;
  assign s_axi_arlen   = 8'd0;
  assign s_axi_arsize  = SIZE;
  assign s_axi_arburst = 2'b01;
  assign s_axi_arlock  = 1'b0;
  assign s_axi_arcache = 4'd0;
  assign s_axi_arprot  = 3'd0;
  // circular search for the first pending requester at or after ptr
  always_comb begin
    g = ptr;
    any = 1'b0;
    idx = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IW'((int'(ptr) + i) % N_REQ);
      if (!any && req_valid[idx]) begin
        g = idx;
        any = 1'b1;
      end
    end
  end
  // state register
  always_ff @(posedge clk) st <= !rstn ? IDLE : st_nxt;
  // next-state logic; a timeout overrides every other transition
  always_comb begin
    st_nxt = tmo                   ? DONE :
             st == IDLE            ? (accept ? ADDR : IDLE) :
             st == ADDR            ? (addr_done ? RESP : ADDR) :
             st == RESP            ? (resp_hs ? DONE : RESP) :
             rsp_ready[gnt]        ? IDLE : DONE;
  end
  // requester-facing outputs decoded from state
  always_comb begin
    req_ready = accept ? N_REQ'(1) << g : '0;
    rsp_valid = st == DONE ? N_REQ'(1) << gnt : '0;
    busy      = st != IDLE;
  end
  // transaction latch, AXI handshake flags, response capture and watchdog
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr           <= '0;
      gnt           <= '0;
      txn_wr        <= 1'b0;
      txn_addr      <= '0;
      txn_wdata     <= '0;
      cnt           <= '0;
      s_axi_awvalid <= 1'b0;
      s_axi_wvalid  <= 1'b0;
      s_axi_arvalid <= 1'b0;
      s_axi_bready  <= 1'b0;
      s_axi_rready  <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      timeout_flag  <= 1'b0;
    end else begin
      if (s_axi_awready) s_axi_awvalid <= 1'b0;
      if (s_axi_wready) s_axi_wvalid <= 1'b0;
      if (s_axi_arready) s_axi_arvalid <= 1'b0;
      if (st == ADDR || st == RESP) cnt <= cnt + 1'b1;
      if (accept) begin
        txn_wr        <= req_write[g];
        txn_addr      <= req_addr[g];
        txn_wdata     <= req_wdata[g];
        gnt           <= g;
        ptr           <= int'(g) == N_REQ - 1 ? '0 : g + 1'b1;
        cnt           <= '0;
        s_axi_awvalid <= req_write[g];
        s_axi_wvalid  <= req_write[g];
        s_axi_arvalid <= !req_write[g];
      end
      if (st == ADDR && addr_done) begin
        s_axi_bready <= txn_wr;
        s_axi_rready <= !txn_wr;
      end
      if (st == RESP && resp_hs) begin
        s_axi_bready <= 1'b0;
        s_axi_rready <= 1'b0;
        rsp_resp     <= txn_wr ? s_axi_bresp : s_axi_rresp;
        rsp_rdata    <= txn_wr ? '0 : s_axi_rdata;
      end
      if (tmo) begin
        s_axi_awvalid <= 1'b0;
        s_axi_wvalid  <= 1'b0;
        s_axi_arvalid <= 1'b0;
        s_axi_bready  <= 1'b0;
        s_axi_rready  <= 1'b0;
        timeout_flag  <= 1'b1;
        rsp_resp      <= 2'b11;
        rsp_rdata     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_axi_reg_arbiter.sv
// tb_axi_reg_arbiter: scoreboard bench with a configurable-latency AXI slave
module tb_axi_reg_arbiter;
  localparam int N = 2, AW = 40, DW = 32, IDW = 6;
  typedef struct packed {logic [N-1:0] oh; logic [DW-1:0] rdata; logic [1:0] resp;} exp_t;
  logic clk = 1'b0, rstn;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic busy, timeout_flag;
  logic [IDW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [3:0] awcache, arcache, wstrb;
  logic [DW-1:0] wdata, rdata;
  int cyc = 0, n_chk = 0, n_pass = 0;
  int aw_dly, w_dly, ar_dly, b_dly, r_dly;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  bit never_b, aw_got, w_got, ar_got;
  logic [DW-1:0] rd_val;
  exp_t sb[$];
  exp_t me;
  int acc, t, prev;

  axi_reg_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .TXN_ID(1), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .timeout_flag(timeout_flag),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache), .s_axi_awprot(awprot),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache), .s_axi_arprot(arprot),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // slave model: decides ready/valid at each negedge for the following posedge
  initial begin
    {awready, wready, arready, bvalid, rvalid} = '0;
    bresp = 2'b00; rresp = 2'b00; rdata = '0;
    {aw_got, w_got, ar_got} = '0;
    {aw_wait, w_wait, ar_wait, b_wait, r_wait} = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        {awready, wready, arready, bvalid, rvalid} = '0;
        {aw_got, w_got, ar_got} = '0;
        {aw_wait, w_wait, ar_wait, b_wait, r_wait} = '0;
      end else begin
        b_wait = (aw_got && w_got) ? b_wait + 1 : 0;
        bvalid = aw_got && w_got && !never_b && b_wait > b_dly;
        if (bvalid && bready) {aw_got, w_got} = 2'b00;
        r_wait = ar_got ? r_wait + 1 : 0;
        rvalid = ar_got && r_wait > r_dly;
        rdata = rvalid ? rd_val : '0;
        if (rvalid && rready) ar_got = 1'b0;
        aw_wait = awvalid ? aw_wait + 1 : 0;
        awready = awvalid && aw_wait > aw_dly;
        if (awvalid && awready) aw_got = 1'b1;
        w_wait = wvalid ? w_wait + 1 : 0;
        wready = wvalid && w_wait > w_dly;
        if (wvalid && wready) w_got = 1'b1;
        ar_wait = arvalid ? ar_wait + 1 : 0;
        arready = arvalid && ar_wait > ar_dly;
        if (arvalid && arready) ar_got = 1'b1;
      end
    end
  end

  // response monitor: pops the scoreboard on every rsp handshake
  initial forever begin
    @(negedge clk);
    #2;
    if (rstn && (rsp_valid & rsp_ready) != '0) begin
      if (sb.size() == 0) check("rsp_unexpected", rsp_valid, 0);
      else begin
        me = sb.pop_front();
        check("rsp_idx", rsp_valid, me.oh);
        check("rsp_rdata", rsp_rdata, me.rdata);
        check("rsp_resp", rsp_resp, me.resp);
      end
    end
  end

  task automatic send(input int idx, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] er, input logic [1:0] eresp, output int at);
    req_write[idx] = wr; req_addr[idx] = a; req_wdata[idx] = d; req_valid[idx] = 1'b1;
    #1;
    for (int k = 0; k < 50 && !req_ready[idx]; k++) tick();
    check("accept", req_ready[idx], 1);
    at = cyc;
    sb.push_back('{oh: N'(1) << idx, rdata: er, resp: eresp});
    tick();
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(output int at);
    for (int k = 0; k < 80 && rsp_valid == '0; k++) tick();
    check("rsp_seen", |rsp_valid, 1);
    at = cyc;
  endtask

  task automatic set_slave(input int a, input int w, input int ar, input int b, input int r);
    aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rsp_ready = '1;
    never_b = 1'b0; rd_val = '0; set_slave(0, 0, 0, 0, 0);
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_axi", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("rst_rsp", {rsp_rdata, rsp_resp, timeout_flag}, 0);
    rstn = 1'b1;
    tick();
    // minimum-latency write from requester 0
    send(0, 1'b1, 40'hA0000010, 32'h12345678, 32'h0, 2'b00, acc);
    check("t1_valids", {awvalid, wvalid}, 2'b11);
    check("t1_awaddr", awaddr, 40'hA0000010);
    check("t1_wdata", wdata, 32'h12345678);
    check("t1_consts", {awlen, awsize, awburst, wstrb, wlast, awid}, {8'd0, 3'd2, 2'b01, 4'hF, 1'b1, 6'd1});
    req_valid[1] = 1'b1;
    #1;
    check("ready_not_idle", req_ready, 0);
    tick();
    check("ready_not_idle2", req_ready, 0);
    req_valid[1] = 1'b0;
    wait_rsp(t);
    check("wr_latency", t - acc, 3);
    tick();
    // read with slow arready/rvalid, response held while rsp_ready low
    set_slave(0, 0, 5, 0, 3); rd_val = 32'hCAFEF00D; rsp_ready = '0;
    send(0, 1'b0, 40'hA0000010, 32'h0, 32'hCAFEF00D, 2'b00, acc);
    for (int k = 0; k < 20; k++) begin
      check("ar_hold", {arvalid, araddr}, {1'b1, 40'hA0000010});
      if (arready) break;
      tick();
    end
    wait_rsp(t);
    tick();
    check("rsp_hold1", {rsp_valid, rsp_rdata}, {2'b01, 32'hCAFEF00D});
    tick();
    check("rsp_hold2", {rsp_valid, rsp_rdata, rsp_resp}, {2'b01, 32'hCAFEF00D, 2'b00});
    rsp_ready = '1;
    tick();
    // write where W completes 4 cycles before AW
    set_slave(4, 0, 0, 0, 0);
    send(1, 1'b1, 40'hA0000020, 32'hDEADBEEF, 32'h0, 2'b00, acc);
    check("t3_both", {awvalid, wvalid}, 2'b11);
    tick();
    check("w_drop", {awvalid, wvalid, bready}, 3'b100);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!awvalid) break;
      check("bready_early", bready, 0);
    end
    check("bready_rise", {awvalid, bready}, 2'b01);
    wait_rsp(t);
    tick();
    // both requesters continuously pending: alternate grants, 4-cycle spacing
    set_slave(0, 0, 0, 0, 0); rd_val = 32'h5A5A0001;
    req_write = 2'b01; req_addr[0] = 40'hA0000100; req_addr[1] = 40'hA0000104;
    req_wdata[0] = 32'h0000BEEF; req_valid = 2'b11;
    #1;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 10 && req_ready == '0; k++) tick();
      check("rr_grant", req_ready, N'(1) << (i % 2));
      sb.push_back('{oh: N'(1) << (i % 2), rdata: (i % 2) ? rd_val : 32'h0, resp: 2'b00});
      acc = cyc;
      if (i > 0) check("rr_gap", acc - prev, 4);
      prev = acc;
      tick();
    end
    req_valid = '0;
    wait_rsp(t);
    tick();
    // slave never answers B: watchdog aborts at accept+17
    never_b = 1'b1;
    send(0, 1'b1, 40'hA0000030, 32'h11112222, 32'h0, 2'b11, acc);
    while (cyc < acc + 16) tick();
    check("to_early", {rsp_valid, timeout_flag}, 3'b000);
    tick();
    check("to_resp", {rsp_resp, rsp_rdata}, {2'b11, 32'h0});
    check("to_flag", timeout_flag, 1);
    check("to_rsp_valid", rsp_valid, 2'b01);
    check("to_axi_idle", {awvalid, wvalid, arvalid, bready, rready}, 0);
    tick();
    never_b = 1'b0;
    // one-cycle reset during RESP aborts silently
    set_slave(0, 0, 0, 0, 10);
    send(1, 1'b0, 40'hA0000040, 32'h0, 32'h0, 2'b00, acc);
    tick();
    check("in_resp", {busy, rready}, 2'b11);
    rstn = 1'b0;
    tick();
    check("rst_abort", {busy, rsp_valid, awvalid, wvalid, arvalid, bready, rready}, 0);
    check("rst_clears_flag", timeout_flag, 0);
    sb.delete();
    rstn = 1'b1;
    set_slave(0, 0, 0, 0, 0);
    repeat (3) tick();
    check("no_rsp_after_rst", rsp_valid, 0);
    send(0, 1'b1, 40'hA0000050, 32'h87654321, 32'h0, 2'b00, acc);
    wait_rsp(t);
    check("post_rst_latency", t - acc, 3);
    tick();
    tick();
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
